// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and the shared coordinate type for the VGA timing generator.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned HCNT_W = $clog2(DEF_H_TOTAL);
    localparam int unsigned VCNT_W = $clog2(DEF_V_TOTAL);

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: modulo-N position counter with wrap output and active/sync region decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP,
    parameter int unsigned W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         advance,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign wrap   = advance && (cnt == LAST);
    assign active = (cnt < ACT_END);
    assign sync   = (cnt >= SYNC_START) && (cnt < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered blank/hsync/vsync plus line/frame strobes, advancing on pix_en.
// Define VGA_TIMING_GEN_COORD_EN to add registered pix_x/pix_y outputs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   pix_en,
    output logic   blank,
    output logic   hsync,
    output logic   vsync,
    output logic   line_start,
    output logic   frame_start
`ifdef VGA_TIMING_GEN_COORD_EN
    ,
    output coord_t pix_x,
    output coord_t pix_y
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          h_wrap, h_active, h_sync;
    logic          v_wrap, v_active, v_sync;
    logic          v_advance;
    logic          at_origin;
    logic          blank_next;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (HW)
    ) u_h (
        .clk     (clk),
        .reset   (reset),
        .advance (pix_en),
        .cnt     (hcnt),
        .wrap    (h_wrap),
        .active  (h_active),
        .sync    (h_sync)
    );

    assign v_advance = pix_en & h_wrap;

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (VW)
    ) u_v (
        .clk     (clk),
        .reset   (reset),
        .advance (v_advance),
        .cnt     (vcnt),
        .wrap    (v_wrap),
        .active  (v_active),
        .sync    (v_sync)
    );

    assign blank_next = ~(h_active & v_active);

    // at_origin tracks "counters sit at (0,0)": set by reset or a frame wrap,
    // cleared by any other advance; replaces a full-width (0,0) compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            at_origin <= 1'b1;
        end else if (pix_en) begin
            at_origin <= v_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blank       <= 1'b1;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            blank       <= blank_next;
            hsync       <= h_sync;
            vsync       <= v_sync;
            line_start  <= (hcnt == '0);
            frame_start <= at_origin;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_GEN_COORD_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_x <= '0;
            pix_y <= '0;
        end else if (pix_en) begin
            pix_x <= blank_next ? '0 : coord_t'(hcnt);
            pix_y <= blank_next ? '0 : coord_t'(vcnt);
        end
    end
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates the raster timing that the scope display, font overlay and other VGA pixel consumers run from. Produces the following outputs for a 640x480@60 frame:
- blank, hsync and vsync, all active-high internal polarity.
- line_start and frame_start strobes.

It sits between the pixel-clock domain and all display blocks, and drives the DAC/connector sync pins through the board top. It advances only on cycles where pix_en is high, so it runs from the system clock with a divided-rate enable.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch pixels
H_SYNC, 96, hsync width in pixels
H_BP, 48, horizontal back porch pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch lines
V_SYNC, 2, vsync width in lines
V_BP, 33, vertical back porch lines

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
pix_en  in  1  pixel advance enable; 1 = one pixel time elapses this cycle
blank  out  1  1 outside the visible area
hsync  out  1  1 during horizontal sync pixels
vsync  out  1  1 during vertical sync lines, for all pixels of those lines
line_start  out  1  one-clk strobe coincident with the first pixel (h=0) of every line
frame_start  out  1  one-clk strobe coincident with pixel (0,0)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counter widths: hcnt is $clog2(H_TOTAL) bits (10); vcnt is $clog2(V_TOTAL) bits (10).
- Counter advance, on a clk edge with pix_en=1:
  - hcnt increments and wraps H_TOTAL-1 -> 0.
  - When hcnt wraps, vcnt increments and wraps V_TOTAL-1 -> 0.
  - With pix_en=0, the counters hold.
- Horizontal regions: active [0,H_ACTIVE), fp [H_ACTIVE,+H_FP), sync [656,752), bp [752,800).
- Vertical regions: active [0,480), fp [480,490), sync [490,492), bp [492,525).
- Decode:
  - blank = (hcnt>=H_ACTIVE) | (vcnt>=V_ACTIVE).
  - hsync = hcnt in h-sync region.
  - vsync = vcnt in v-sync region, for every hcnt.
- Outputs are registered from the current counter values, giving one clk of latency from counter to pins. All five outputs are mutually aligned, so consumers see a consistent (blank, hsync, vsync) triple.
- Output update rule:
  - On a pix_en=1 cycle, the registered outputs update to reflect the counter position at that edge.
  - On a pix_en=0 cycle, blank/hsync/vsync hold.
  - line_start and frame_start are forced to 0 on any cycle where pix_en was 0, so each strobe lasts exactly one clk.
- Strobes:
  - line_start = 1 when the registered position has hcnt==0 (all lines, including blanked lines).
  - frame_start = 1 when the registered position is hcnt==0 and vcnt==0.
- Reset state:
  - hcnt=0, vcnt=0.
  - blank=1, hsync=0, vsync=0, line_start=0, frame_start=0.
  - The first pix_en=1 cycle after reset registers position (0,0), giving blank=0, line_start=1, frame_start=1.
- Reset mid-frame: immediate return to the reset state on the next edge; there is no partial-line completion.
- pix_en held low indefinitely: the raster freezes with blank/hsync/vsync static and both strobes 0.
- pix_en tied high is legal: the raster runs at clk rate.
- Parameter legality: each parameter must be >=1. The block does not check this at runtime.

Optional Feature:
Macro: VGA_TIMING_GEN_COORD_EN
- With the macro:
  - Adds outputs pix_x[9:0] and pix_y[9:0], registered alongside blank with identical latency and hold rules.
  - Values equal hcnt/vcnt when blank=0, and are forced to 0 when blank=1.
  - Reset value is 0.
- Without the macro: the ports do not exist and consumers keep their own counters. Timing of all other outputs is identical either way.

Decomposition:
- Package vga_timing_pkg holds:
  - The default timing constants (640/16/96/48, 480/10/2/33).
  - Derived H_TOTAL/V_TOTAL.
  - The counter width localparams.
  - A typedef for the 10-bit coordinate.
- One natural sub-module, vga_axis_counter, instantiated twice (horizontal and vertical):
  - Modulo-N counter with an advance input and a wrap output.
  - Region decode outputs: active, sync.
  - The vertical instance advances on horizontal wrap AND pix_en.

Test Plan:
1. Reset, then pix_en=1 continuous for 2 frames -> exactly 420000 clks between frame_start pulses; 800 clks between line_start pulses; 640 blank=0 clks per visible line.
2. Count within one frame -> hsync high 96 consecutive clks starting 656 clks after line_start; vsync high for exactly 1600 clks (2 lines), starting at line 490, pixel 0.
3. pix_en toggling 1/0 (50% duty) -> frame_start period 840000 clks; each strobe is 1 clk wide; blank/hsync/vsync unchanged on pix_en=0 cycles.
4. Reset asserted at line 300, pixel 400 -> next clk blank=1, hsync=0, vsync=0; first pix_en=1 after release gives frame_start=1, blank=0.
5. Boundary: pixel 799 of line 524 followed by the next pix_en -> blank 1->0, frame_start=1, line_start=1 on the same clk.
6. With VGA_TIMING_GEN_COORD_EN -> pix_x=639, pix_y=479 on the last visible pixel; pix_x=0, pix_y=0 throughout the blanking interval.
